// File: rtl/udc_pkg.sv
// Shared definitions for the up/down cyclic counter peripheral.
// Holds the FSM state type, the bus register map, and the bit positions
// of the CTRL and STATUS registers so the regfile and the counter core
// agree on them.
package udc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEG_A = 2'd1,
    LEG_B = 2'd2,
    LEG_C = 2'd3
  } udc_state_t;

  localparam logic [2:0] ADDR_PLR         = 3'd0;
  localparam logic [2:0] ADDR_ULR         = 3'd1;
  localparam logic [2:0] ADDR_LLR         = 3'd2;
  localparam logic [2:0] ADDR_CCR         = 3'd3;
  localparam logic [2:0] ADDR_CTRL        = 3'd4;
  localparam logic [2:0] ADDR_STATUS      = 3'd5;
  localparam logic [2:0] ADDR_CYCLES_LEFT = 3'd6;
  localparam logic [2:0] ADDR_COUNT       = 3'd7;

  localparam int unsigned CTRL_START      = 0;
  localparam int unsigned CTRL_ABORT      = 1;
  localparam int unsigned CTRL_DOWN_FIRST = 2;
  localparam int unsigned CTRL_CONTINUOUS = 3;

  localparam int unsigned ST_BUSY   = 0;
  localparam int unsigned ST_DIR    = 1;
  localparam int unsigned ST_ERR    = 2;
  localparam int unsigned ST_WR_REJ = 3;

endpackage

// File: rtl/udc_regfile.sv
// Bus-side register file of the cyclic counter.
// Decodes the chip-select/read/write strobes, holds the limit registers
// (PLR/ULR/LLR/CCR) and CTRL mode bits, locks the limits while a profile
// runs (flagging rejected writes in sticky wr_rej), and registers read data.
// Ports:
//   clk_i, rst_ni          clock, async active-low reset
//   ncs_i, nrd_i, nwr_i    active-low bus strobes
//   addr_i, din_i          register address / write data
//   busy_i, dir_i          live counter status
//   cycles_left_i, count_i live counter values for read-back
//   plr_o..ccr_o           limit registers
//   down_first_o, continuous_o  CTRL mode bits
//   start_wr_o, abort_wr_o one-cycle CTRL command strobes
//   err_o                  limits inconsistent (combinational)
//   dout_o, dout_en_o      registered read data / read enable
module udc_regfile
  import udc_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CCR_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ncs_i,
  input  logic                 nrd_i,
  input  logic                 nwr_i,
  input  logic [2:0]           addr_i,
  input  logic [WIDTH-1:0]     din_i,
  input  logic                 busy_i,
  input  logic                 dir_i,
  input  logic [CCR_WIDTH-1:0] cycles_left_i,
  input  logic [WIDTH-1:0]     count_i,
  output logic [WIDTH-1:0]     plr_o,
  output logic [WIDTH-1:0]     ulr_o,
  output logic [WIDTH-1:0]     llr_o,
  output logic [CCR_WIDTH-1:0] ccr_o,
  output logic                 down_first_o,
  output logic                 continuous_o,
  output logic                 start_wr_o,
  output logic                 abort_wr_o,
  output logic                 err_o,
  output logic [WIDTH-1:0]     dout_o,
  output logic                 dout_en_o
);

  logic [WIDTH-1:0]     plr_q, plr_d, ulr_q, ulr_d, llr_q, llr_d;
  logic [CCR_WIDTH-1:0] ccr_q, ccr_d;
  logic                 df_q, df_d, cont_q, cont_d;
  logic                 wr_rej_q, wr_rej_d;
  logic [WIDTH-1:0]     dout_q, dout_d;
  logic                 rd_en, wr_en, lim_wr;
  logic [WIDTH-1:0]     rdata;
  logic [3:0]           status, ctrl_rd;

  // A write takes precedence when both strobes are low.
  assign wr_en     = !ncs_i && !nwr_i;
  assign rd_en     = !ncs_i && !nrd_i && nwr_i;
  assign lim_wr    = wr_en && (addr_i <= ADDR_CCR);
  assign dout_en_o = rd_en;

  assign err_o = !((llr_q <= plr_q) && (plr_q <= ulr_q));

  assign start_wr_o = wr_en && (addr_i == ADDR_CTRL) && din_i[CTRL_START];
  assign abort_wr_o = wr_en && (addr_i == ADDR_CTRL) && din_i[CTRL_ABORT];

  always_comb begin
    plr_d  = plr_q;
    ulr_d  = ulr_q;
    llr_d  = llr_q;
    ccr_d  = ccr_q;
    df_d   = df_q;
    cont_d = cont_q;
    if (wr_en) begin
      case (addr_i)
        ADDR_PLR:  if (!busy_i) plr_d = din_i;
        ADDR_ULR:  if (!busy_i) ulr_d = din_i;
        ADDR_LLR:  if (!busy_i) llr_d = din_i;
        ADDR_CCR:  if (!busy_i) ccr_d = din_i[CCR_WIDTH-1:0];
        ADDR_CTRL: begin
          df_d   = din_i[CTRL_DOWN_FIRST];
          cont_d = din_i[CTRL_CONTINUOUS];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    wr_rej_d = wr_rej_q;
    if (lim_wr && busy_i)
      wr_rej_d = 1'b1;
    else if (rd_en && (addr_i == ADDR_STATUS))
      wr_rej_d = 1'b0;
  end

  always_comb begin
    status            = '0;
    status[ST_BUSY]   = busy_i;
    status[ST_DIR]    = dir_i;
    status[ST_ERR]    = err_o;
    status[ST_WR_REJ] = wr_rej_q;
    ctrl_rd                  = '0;
    ctrl_rd[CTRL_DOWN_FIRST] = df_q;
    ctrl_rd[CTRL_CONTINUOUS] = cont_q;
    case (addr_i)
      ADDR_PLR:         rdata = plr_q;
      ADDR_ULR:         rdata = ulr_q;
      ADDR_LLR:         rdata = llr_q;
      ADDR_CCR:         rdata = WIDTH'(ccr_q);
      ADDR_CTRL:        rdata = WIDTH'(ctrl_rd);
      ADDR_STATUS:      rdata = WIDTH'(status);
      ADDR_CYCLES_LEFT: rdata = WIDTH'(cycles_left_i);
      default:          rdata = count_i;
    endcase
    dout_d = rd_en ? rdata : dout_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      plr_q    <= '0;
      ulr_q    <= '1;
      llr_q    <= '0;
      ccr_q    <= '0;
      df_q     <= 1'b0;
      cont_q   <= 1'b0;
      wr_rej_q <= 1'b0;
      dout_q   <= '0;
    end else begin
      plr_q    <= plr_d;
      ulr_q    <= ulr_d;
      llr_q    <= llr_d;
      ccr_q    <= ccr_d;
      df_q     <= df_d;
      cont_q   <= cont_d;
      wr_rej_q <= wr_rej_d;
      dout_q   <= dout_d;
    end
  end

  assign plr_o        = plr_q;
  assign ulr_o        = ulr_q;
  assign llr_o        = llr_q;
  assign ccr_o        = ccr_q;
  assign down_first_o = df_q;
  assign continuous_o = cont_q;
  assign dout_o       = dout_q;

endmodule

// File: rtl/udc_cyclic_counter_p.sv
// Parametrised up/down cyclic counter peripheral.
// Runs the profile PLR->ULR->LLR->PLR (or PLR->LLR->ULR->PLR when
// down_first is set) CCR times, or forever in continuous mode, stepping one
// count per clock with a single dwell clock at each turning point.
// Ports:
//   clk, reset             clock, async active-low reset
//   ncs, nrd, nwr, addr, din, dout, dout_en   peripheral bus
//   start_in               start request (rising edge)
//   cout                   live count
//   dir                    1 = last step up, 0 = down or idle
//   busy                   profile running
//   ec                     one-cycle end-of-count pulse
//   err                    limits inconsistent
module udc_cyclic_counter_p
  import udc_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CCR_WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ncs,
  input  logic             nrd,
  input  logic             nwr,
  input  logic [2:0]       addr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             dout_en,
  input  logic             start_in,
  output logic [WIDTH-1:0] cout,
  output logic             dir,
  output logic             busy,
  output logic             ec,
  output logic             err
);

  udc_state_t           state_q, state_d;
  logic [WIDTH-1:0]     cout_q, cout_d;
  logic                 dir_q, dir_d;
  logic                 ec_q, ec_d;
  logic [CCR_WIDTH-1:0] cycles_q, cycles_d;
  logic                 start_prev_q;

  logic [WIDTH-1:0]     plr, ulr, llr, target;
  logic [CCR_WIDTH-1:0] ccr;
  logic                 down_first, continuous, start_wr, abort_wr;
  logic                 start_rise, start_acc;

  udc_regfile #(
    .WIDTH     (WIDTH),
    .CCR_WIDTH (CCR_WIDTH)
  ) u_regfile (
    .clk_i         (clk),
    .rst_ni        (reset),
    .ncs_i         (ncs),
    .nrd_i         (nrd),
    .nwr_i         (nwr),
    .addr_i        (addr),
    .din_i         (din),
    .busy_i        (busy),
    .dir_i         (dir_q),
    .cycles_left_i (cycles_q),
    .count_i       (cout_q),
    .plr_o         (plr),
    .ulr_o         (ulr),
    .llr_o         (llr),
    .ccr_o         (ccr),
    .down_first_o  (down_first),
    .continuous_o  (continuous),
    .start_wr_o    (start_wr),
    .abort_wr_o    (abort_wr),
    .err_o         (err),
    .dout_o        (dout),
    .dout_en_o     (dout_en)
  );

  assign busy       = (state_q != IDLE);
  assign start_rise = start_in && !start_prev_q;
  assign start_acc  = (start_rise || start_wr) && !ncs && !busy && !err;

  always_comb begin
    case (state_q)
      LEG_A:   target = down_first ? llr : ulr;
      LEG_B:   target = down_first ? ulr : llr;
      default: target = plr;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cout_d   = cout_q;
    dir_d    = dir_q;
    ec_d     = 1'b0;
    cycles_d = cycles_q;
    if (state_q == IDLE) begin
      if (start_acc) begin
        cout_d   = plr;
        cycles_d = ccr;
        state_d  = LEG_A;
      end
    end else if (abort_wr) begin
      state_d = IDLE;
      dir_d   = 1'b0;
    end else if (state_q == LEG_A && cycles_q == '0 && !continuous) begin
      // Zero cycle count: end the run on the first leg cycle without moving.
      state_d = IDLE;
      dir_d   = 1'b0;
      ec_d    = 1'b1;
    end else if (cout_q != target) begin
      if (cout_q < target) begin
        cout_d = cout_q + WIDTH'(1);
        dir_d  = 1'b1;
      end else begin
        cout_d = cout_q - WIDTH'(1);
        dir_d  = 1'b0;
      end
    end else begin
      // Dwell at the turning point: dir keeps the finished leg's direction.
      case (state_q)
        LEG_A: state_d = LEG_B;
        LEG_B: state_d = LEG_C;
        default: begin
          if (continuous) begin
            state_d = LEG_A;
          end else if (cycles_q <= CCR_WIDTH'(1)) begin
            cycles_d = '0;
            state_d  = IDLE;
            dir_d    = 1'b0;
            ec_d     = 1'b1;
          end else begin
            cycles_d = cycles_q - CCR_WIDTH'(1);
            state_d  = LEG_A;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cout_q       <= '0;
      dir_q        <= 1'b0;
      ec_q         <= 1'b0;
      cycles_q     <= '0;
      start_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cout_q       <= cout_d;
      dir_q        <= dir_d;
      ec_q         <= ec_d;
      cycles_q     <= cycles_d;
      start_prev_q <= start_in;
    end
  end

  assign cout = cout_q;
  assign dir  = dir_q;
  assign ec   = ec_q;

endmodule

// File: doc/udc_cyclic_counter_p.md
# udc_cyclic_counter_p

Parametrised successor to the 8-bit up/down cyclic counter. Host-programmable limits (preload, upper, lower, cycle count) drive a repeating count profile PLR→ULR→LLR→PLR, or PLR→LLR→ULR→PLR in down-first mode. Additions over the previous generation:
- generic width
- continuous mode and host abort
- readable status and live count
- a strict no-Z, single-driver output style

The block sits on the chip-select/read/write peripheral bus alongside the other counter peripherals.

## Interface
- WIDTH, 8: count and data-bus width (≥2).
- CCR_WIDTH, 8: cycle-count register width (≤ WIDTH).
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  asynchronous, active-low; clears all state.
- ncs, nrd, nwr  in  1 each  active-low chip select / read / write strobes.
- addr  in  3  register address.
- din  in  WIDTH  write data.
- dout  out  WIDTH  registered read data.
- dout_en  out  1  combinational: !ncs && !nrd && nwr.
- start_in  in  1  start request, rising-edge detected.
- cout  out  WIDTH  current count.
- dir  out  1  1 = up, 0 = down/idle.
- busy  out  1  profile running.
- ec  out  1  end-of-count, one-cycle pulse.
- err  out  1  limits invalid: !(LLR ≤ PLR ≤ ULR), combinational.

## Operation
- Register map (addr):
  - 0 PLR, 1 ULR, 2 LLR: WIDTH bits each.
  - 3 CCR: CCR_WIDTH bits, zero-extended on read.
  - 4 CTRL: bit0 start (self-clearing), bit1 abort (self-clearing), bit2 down_first, bit3 continuous.
  - 5 STATUS (read-only): {wr_rej, err, dir, busy} in bits 3:0.
  - 6 CYCLES_LEFT (read-only).
  - 7 COUNT (read-only).
- Reset values:
  - PLR=0, ULR=all-ones, LLR=0, CCR=0, CTRL=0.
  - cout=0, dir=0, busy=0, ec=0, dout=0, wr_rej=0.
- Writes (ncs=0, nwr=0, sampled on the clock edge):
  - While busy, writes to addr 0–3 are dropped and set sticky wr_rej.
  - Reading STATUS clears wr_rej.
  - CTRL is always writable.
  - If nrd and nwr are both low, the write executes and no read occurs.
- Reads (ncs=0, nrd=0, nwr=1): dout loads the addressed register on the edge; dout holds otherwise.
- Start trigger: start_in rising edge (previous sample 0, current 1), or a CTRL write with bit0=1. Accepted only when ncs=0, busy=0 and err=0; otherwise ignored with no side effect.
- State machine, udc_state_t: IDLE, LEG_A, LEG_B, LEG_C.
  - Accepted start: cout←PLR, cycles_left←CCR, busy←1, state←LEG_A.
  - LEG_A targets ULR (down_first=0) or LLR (down_first=1).
  - LEG_B targets the other limit.
  - LEG_C targets PLR.
  - Per cycle in a leg: if cout≠target, step ±1 toward the target; otherwise advance to the next leg with no step (one dwell cycle at each turning point).
  - dir=1 while stepping up, 0 while stepping down; during a dwell, dir shows the direction of the leg just finished.
- LEG_C dwell:
  - continuous=1: go to LEG_A; cycles_left unchanged.
  - Otherwise: cycles_left−1. If the result is 0, go to IDLE, busy←0, ec←1 for one cycle, cout holds PLR. If non-zero, go to LEG_A.
- Start with CCR=0 and continuous=0: no counting. On the next edge, busy returns to 0 and ec pulses once.
- Abort (CTRL bit1 while busy): go to IDLE on that edge; cout holds; no ec. If start and abort are written together: abort wins when busy, start wins when idle.
- dir is 0 whenever idle.
- Arithmetic is unsigned. Steps never pass a limit (targets are bounded by err=0), so no wrap-around occurs.
- Async reset mid-run forces all reset values immediately; no ec.

## Timing
- Start-to-first-step: cout=PLR after the accepting edge; first increment/decrement on the next edge.
- Cycle length in clocks: |ULR−PLR| + (ULR−LLR) + |PLR−LLR| + 3 dwells.
- ec is high for exactly the one cycle in which busy first reads 0.
- A new start is accepted on the cycle after ec.

## Structure
- Shared package udc_pkg:
  - udc_state_t enum.
  - Address constants ADDR_PLR … ADDR_COUNT.
  - CTRL bit indices.
  - STATUS bit indices.
- Sub-module udc_regfile: bus decode, limit registers, write lock, wr_rej, read mux, dout register.
- The top level holds the edge detector, FSM and counter datapath.

## Test plan
- PLR=2, ULR=5, LLR=0, CCR=1, up-first, start_in pulse → cout 2,3,4,5,5,4,3,2,1,0,0,1,2,2; ec on the 14th edge after start; busy falls with it.
- Same limits, down_first=1, CCR=2 → two profiles 2→0→5→2; ec once; CYCLES_LEFT reads 1 mid-run, 0 at end.
- PLR=9, ULR=5 → err=1; start_in ignored (busy stays 0). Write PLR=3 → err=0; start accepted.
- Write ULR=7 while busy → ULR unchanged; STATUS reads wr_rej=1; a second STATUS read shows 0.
- continuous=1, CCR=1, run 3 profiles, then CTRL abort → busy=0 next edge, no ec, cout frozen.
- reset low mid-LEG_B → cout=0, dir=0, busy=0, ULR=0xFF asynchronously; CCR=0 start → single ec, no count.
